stack_arbiter: RTL and testbench
================================

Name: stack_arbiter

Overview:
Two-requester arbiter and sequencer for the shared 8-bit push/pop stack. It takes push/pop transactions from two independent clients over a req/ack handshake and grants one transaction at a time. It drives the stack's push/pop/data_in pins and returns popped data to the owning client. It tracks occupancy so that overflow and underflow requests are refused without touching the stack.

Parameters:
WIDTH, 8, data width of stack entries and client data buses
DEPTH, 16, stack capacity in entries; occupancy limit for push acceptance
CNT_W, 5, occupancy counter width; must hold DEPTH, i.e. CNT_W >= clog2(DEPTH+1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
req0  input  1  client 0 transaction request, held until ack0
op0  input  1  client 0 operation: 1 = push, 0 = pop; stable while req0 high
din0  input  WIDTH  client 0 push data; stable while req0 high
ack0  output  1  client 0 completion pulse, one cycle
err0  output  1  client 0 refused (full/empty); valid with ack0
dout0  output  WIDTH  client 0 popped data; valid with ack0 on a good pop
req1, op1, din1, ack1, err1, dout1  same directions, widths and meanings as above, for client 1
stk_push  output  1  stack push strobe
stk_pop  output  1  stack pop strobe
stk_din  output  WIDTH  stack data_in
stk_dout  input  WIDTH  stack data_out
count  output  CNT_W  current occupancy
full  output  1  count == DEPTH
empty  output  1  count == 0

Behaviour:
- Reset (reset low, async): state IDLE, count 0, last_grant 1. All ack/err/stk_push/stk_pop are 0, all dout and stk_din are 0, empty 1, full 0. The stack instance shares the same reset event; a reset mid-transaction abandons the transaction with no ack.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE: sample req0/req1.
  - None set: stay in IDLE.
  - One set: grant that client.
  - Both set: grant the client not equal to last_grant. last_grant updates on every grant.
- IDLE, granted request legal: latch op and din into stk_din and go to ISSUE. Legal means a push with count < DEPTH, or a pop with count > 0.
- IDLE, granted request illegal: go to ACK with err set. No stack strobe; count unchanged.
- ISSUE: exactly one cycle with stk_push or stk_pop = 1. Count +1 on push, -1 on pop, at the end of ISSUE. Push goes to ACK; pop goes to WAIT.
- WAIT: the stack presents popped data. Capture stk_dout into the granted client's dout at the end of WAIT, then go to ACK.
- ACK: ack of the granted client = 1 for exactly one cycle, with err set only for refusals. Return to IDLE.
- Latency from req sampled in IDLE to ack high:
  - push: 2 cycles
  - pop: 3 cycles
  - refusal: 1 cycle
- Client rule: drop or replace req/op/din at the clock edge that ends ack. The arbiter never re-samples req during ACK, so there is no double service.
- dout holds its last value until the next good pop for that client. err is 0 whenever ack is 0.
- count never wraps: pushes at full and pops at empty are always refused.
- Non-granted request: stays pending with no timeout. It is served in the next IDLE arbitration. Round-robin guarantees service within one transaction of the other client.

Optional Feature:
STACK_ARB_FIXED_PRIO_EN
- Defined: fixed priority. Client 0 always wins when both req are high; last_grant is unused and client 1 may starve.
- Undefined (default): round-robin as described above.

Test Plan:
- Reset low mid-push (ISSUE state) -> all outputs 0, empty 1, count 0; after release, IDLE with no ack.
- Client 0 pushes 8'hA4 -> stk_push high one cycle 1 clock after req, ack0 2 clocks after req, count 1. Client 0 then pops -> ack0 3 clocks after req with dout0 = 8'hA4, err0 0, count 0.
- Client 1 pops at empty -> ack1 + err1 the next cycle, stk_pop never asserted, count stays 0.
- Both clients request a push (8'h11, 8'h22) in the same cycle after reset -> client 0 served first, then client 1. Two pops by client 0 return 8'h22 then 8'h11.
- DEPTH = 4: four pushes accepted, full = 1; fifth push (8'hC2) -> err, count stays 4, no stk_push.
- With STACK_ARB_FIXED_PRIO_EN, both clients requesting continuously -> only ack0 pulses; without the macro, ack0 and ack1 alternate.

Source files
------------

// File: rtl/stack_arbiter.sv
// Two-client req/ack arbiter and sequencer for a shared push/pop stack.
// Define STACK_ARB_FIXED_PRIO_EN for fixed priority (client 0 wins).
module stack_arbiter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             op0,
  input  logic [WIDTH-1:0] din0,
  output logic             ack0,
  output logic             err0,
  output logic [WIDTH-1:0] dout0,
  input  logic             req1,
  input  logic             op1,
  input  logic [WIDTH-1:0] din1,
  output logic             ack1,
  output logic             err1,
  output logic [WIDTH-1:0] dout1,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [WIDTH-1:0] stk_din,
  input  logic [WIDTH-1:0] stk_dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, ACK
  } state_e;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  state_e           state_q;
  logic             gnt_q;
  logic             op_q;
  logic             ack0_q, ack1_q;
  logic             err0_q, err1_q;
  logic [WIDTH-1:0] dout0_q, dout1_q;
  logic             push_q, pop_q;
  logic [WIDTH-1:0] sdin_q;
  logic [CNT_W-1:0] cnt_q;
  logic             full_q, empty_q;
`ifndef STACK_ARB_FIXED_PRIO_EN
  logic             last_q;
`endif

  logic             any_d;
  logic             gnt_d;
  logic             op_d;
  logic [WIDTH-1:0] din_d;
  logic             legal_d;

  // Pick the winner among pending requests and judge its legality.
  always_comb begin
    any_d = req0 | req1;
`ifdef STACK_ARB_FIXED_PRIO_EN
    gnt_d = ~req0;
`else
    gnt_d = (req0 & req1) ? ~last_q : req1;
`endif
    op_d    = gnt_d ? op1 : op0;
    din_d   = gnt_d ? din1 : din0;
    legal_d = op_d ? (cnt_q < DEPTH_C) : (cnt_q != '0);
  end

  // Transaction FSM; every output is a register written here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      op_q    <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
      dout0_q <= '0;
      dout1_q <= '0;
      push_q  <= 1'b0;
      pop_q   <= 1'b0;
      sdin_q  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
`ifndef STACK_ARB_FIXED_PRIO_EN
      last_q  <= 1'b1;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (any_d) begin
            gnt_q <= gnt_d;
            op_q  <= op_d;
`ifndef STACK_ARB_FIXED_PRIO_EN
            last_q <= gnt_d;
`endif
            if (legal_d) begin
              sdin_q  <= din_d;
              push_q  <= op_d;
              pop_q   <= ~op_d;
              state_q <= ISSUE;
            end else begin
              ack0_q  <= ~gnt_d;
              ack1_q  <= gnt_d;
              err0_q  <= ~gnt_d;
              err1_q  <= gnt_d;
              state_q <= ACK;
            end
          end
        end
        ISSUE: begin
          push_q <= 1'b0;
          pop_q  <= 1'b0;
          if (op_q) begin
            cnt_q   <= cnt_q + ONE_C;
            full_q  <= (cnt_q + ONE_C) == DEPTH_C;
            empty_q <= 1'b0;
            ack0_q  <= ~gnt_q;
            ack1_q  <= gnt_q;
            state_q <= ACK;
          end else begin
            cnt_q   <= cnt_q - ONE_C;
            full_q  <= 1'b0;
            empty_q <= cnt_q == ONE_C;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (gnt_q) dout1_q <= stk_dout;
          else       dout0_q <= stk_dout;
          ack0_q  <= ~gnt_q;
          ack1_q  <= gnt_q;
          state_q <= ACK;
        end
        ACK: begin
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          err0_q  <= 1'b0;
          err1_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign err0     = err0_q;
  assign err1     = err1_q;
  assign dout0    = dout0_q;
  assign dout1    = dout1_q;
  assign stk_push = push_q;
  assign stk_pop  = pop_q;
  assign stk_din  = sdin_q;
  assign count    = cnt_q;
  assign full     = full_q;
  assign empty    = empty_q;

endmodule

// File: tb/tb_stack_arbiter.sv
// Bench for stack_arbiter: directed steps then random traffic,
// checked against a queue-based stack and occupancy model.
module tb_stack_arbiter;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req0 = 0, op0 = 0, req1 = 0, op1 = 0;
  logic [W-1:0]  din0 = '0, din1 = '0;
  logic          ack0, err0, ack1, err1;
  logic [W-1:0]  dout0, dout1;
  logic          stk_push, stk_pop;
  logic [W-1:0]  stk_din, stk_dout;
  logic [CW-1:0] count;
  logic          full, empty;

  always #5 clk = ~clk;

  stack_arbiter #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .op0(op0), .din0(din0),
    .ack0(ack0), .err0(err0), .dout0(dout0),
    .req1(req1), .op1(op1), .din1(din1),
    .ack1(ack1), .err1(err1), .dout1(dout1),
    .stk_push(stk_push), .stk_pop(stk_pop),
    .stk_din(stk_din), .stk_dout(stk_dout),
    .count(count), .full(full), .empty(empty)
  );

  // Simple registered-output stack attached to the arbiter.
  logic [W-1:0]  mem [D];
  logic [CW-1:0] sp;

  always_ff @(posedge clk)
    if (reset && stk_push && sp < CW'(D)) mem[sp[1:0]] <= stk_din;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sp       <= '0;
      stk_dout <= '0;
    end else if (stk_push && sp < CW'(D)) begin
      sp <= sp + 1'b1;
    end else if (stk_pop && sp != '0) begin
      stk_dout <= mem[sp[1:0] - 2'd1];
      sp       <= sp - 1'b1;
    end

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] model_q [$];
  logic [W-1:0] dout_m [2];
  bit           last_m;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int c, input logic v, input logic op,
                         input logic [W-1:0] d);
    if (c == 0) begin req0 = v; op0 = op; din0 = d; end
    else        begin req1 = v; op1 = op; din1 = d; end
  endtask

  task automatic model(input int c, input bit op, input logic [W-1:0] d,
                       output bit err);
    err = 1'b0;
    if (op) begin
      if (model_q.size() < D) model_q.push_back(d);
      else err = 1'b1;
    end else begin
      if (model_q.size() > 0) dout_m[c] = model_q.pop_back();
      else err = 1'b1;
    end
  endtask

  task automatic chk_occ(input string tag);
    chk({tag, "_count"}, 32'(count), model_q.size());
    chk({tag, "_full"}, 32'(full), 32'(model_q.size() == D));
    chk({tag, "_empty"}, 32'(empty), 32'(model_q.size() == 0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    req0 = 0; req1 = 0;
    @(negedge clk);
    reset = 1'b1;
    model_q.delete();
    dout_m[0] = '0;
    dout_m[1] = '0;
    last_m = 1'b1;
  endtask

  task automatic txn(input int c, input bit op, input logic [W-1:0] d);
    bit   err;
    int   lat;
    int   exp_lat;
    logic a;
    model(c, op, d, err);
    exp_lat = err ? 1 : (op ? 2 : 3);
    @(negedge clk);
    set_req(c, 1'b1, op, d);
    lat = 0;
    a = 1'b0;
    while (!a && lat < 12) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        chk("push_strobe", 32'(stk_push), 32'(!err && op));
        chk("pop_strobe", 32'(stk_pop), 32'(!err && !op));
        if (!err && op) chk("stk_din", 32'(stk_din), 32'(d));
      end
      a = (c == 0) ? ack0 : ack1;
    end
    chk("ack_seen", 32'(a), 32'd1);
    chk("latency", lat, exp_lat);
    chk("err", 32'((c == 0) ? err0 : err1), 32'(err));
    chk("dout", 32'((c == 0) ? dout0 : dout1), 32'(dout_m[c]));
    chk("other_ack", 32'((c == 0) ? ack1 : ack0), 32'd0);
    chk_occ("txn");
    set_req(c, 1'b0, 1'b0, '0);
    last_m = c[0];
  endtask

  task automatic pair(input bit o0, input logic [W-1:0] d0,
                      input bit o1, input logic [W-1:0] d1);
    int           first;
    int           c;
    int           seen;
    int           cyc;
    bit           e [2];
    logic [W-1:0] dx [2];
    bit           ov [2];
    logic [W-1:0] dv [2];
    ov[0] = o0; ov[1] = o1;
    dv[0] = d0; dv[1] = d1;
`ifdef STACK_ARB_FIXED_PRIO_EN
    first = 0;
`else
    first = last_m ? 0 : 1;
`endif
    model(first, ov[first], dv[first], e[first]);
    dx[first] = dout_m[first];
    model(1 - first, ov[1 - first], dv[1 - first], e[1 - first]);
    dx[1 - first] = dout_m[1 - first];
    @(negedge clk);
    set_req(0, 1'b1, o0, d0);
    set_req(1, 1'b1, o1, d1);
    seen = 0;
    cyc = 0;
    while (seen < 2 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (ack0 || ack1) begin
        c = ack1 ? 1 : 0;
        chk("dual_ack", 32'(ack0 && ack1), 32'd0);
        chk("order", c, (seen == 0) ? first : 1 - first);
        chk("pair_err", 32'(c == 0 ? err0 : err1), 32'(e[c]));
        chk("pair_dout", 32'(c == 0 ? dout0 : dout1), 32'(dx[c]));
        set_req(c, 1'b0, 1'b0, '0);
        seen++;
      end
    end
    chk("pair_done", seen, 2);
    chk_occ("pair");
    last_m = (1 - first) != 0;
  endtask

  initial begin
    int   seq_exp;
    int   got;
    int   cyc;
    logic any_ack;
    logic [W-1:0] rd;

    last_m = 1'b1;
    dout_m[0] = '0;
    dout_m[1] = '0;

    // Reset state, then reset abandoning a push in ISSUE
    repeat (2) @(negedge clk);
    chk("rst_ack0", 32'(ack0), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 8'hA5);
    @(negedge clk);
    chk("issue_push", 32'(stk_push), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid_ack", 32'({ack0, ack1, err0, err1}), 32'd0);
    chk("mid_strobe", 32'({stk_push, stk_pop}), 32'd0);
    chk("mid_data", 32'({stk_din, dout0, dout1}), 32'd0);
    chk("mid_count", 32'(count), 32'd0);
    chk("mid_flags", 32'({empty, full}), 32'b10);
    set_req(0, 1'b0, 1'b0, '0);
    @(negedge clk);
    reset = 1'b1;
    any_ack = 1'b0;
    repeat (4) begin
      @(negedge clk);
      any_ack = any_ack | ack0 | ack1;
    end
    chk("post_rst_noack", 32'(any_ack), 32'd0);
    chk_occ("post_rst");

    // Push A4 then pop it back
    txn(0, 1'b1, 8'hA4);
    txn(0, 1'b0, 8'h00);

    // Pop at empty refused
    txn(1, 1'b0, 8'h00);

    // Simultaneous pushes after reset, then LIFO pops
    do_reset();
    pair(1'b1, 8'h11, 1'b1, 8'h22);
    txn(0, 1'b0, 8'h00);
    chk("lifo_22", 32'(dout0), 32'h22);
    txn(0, 1'b0, 8'h00);
    chk("lifo_11", 32'(dout0), 32'h11);

    // Fill to capacity, then overflow refused
    for (int i = 0; i < D; i++) txn(0, 1'b1, 8'(8'h30 + i));
    chk("full_set", 32'(full), 32'd1);
    txn(0, 1'b1, 8'hC2);
    chk("full_cnt", 32'(count), 32'(D));

    // Both clients requesting continuously (refused pushes)
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 8'hE0);
    set_req(1, 1'b1, 1'b1, 8'hE1);
`ifdef STACK_ARB_FIXED_PRIO_EN
    seq_exp = 0;
`else
    seq_exp = last_m ? 0 : 1;
`endif
    got = 0;
    cyc = 0;
    while (got < 6 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (ack0 || ack1) begin
        chk("cont_grant", 32'(ack1 ? 1 : 0), seq_exp);
        chk("cont_err", 32'(ack1 ? err1 : err0), 32'd1);
        last_m = ack1;
`ifndef STACK_ARB_FIXED_PRIO_EN
        seq_exp = 1 - seq_exp;
`endif
        got++;
      end
    end
    chk("cont_done", got, 6);
    set_req(0, 1'b0, 1'b0, '0);
    set_req(1, 1'b0, 1'b0, '0);
    chk_occ("cont");

    // Random traffic
    for (int i = 0; i < 150; i++) begin
      rd = 8'($urandom);
      if ($urandom_range(0, 3) == 0)
        pair(1'($urandom), rd, 1'($urandom), 8'($urandom));
      else
        txn(int'($urandom_range(0, 1)), 1'($urandom), rd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
